// File: rtl/char_receive_controller.sv
// Serial character-receive sequencer: synchronizes the line, times start/data/stop
// bits on an oversample tick, and hands LSB-first characters out over valid/ready.
module char_receive_controller #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 rx_in,
  input  logic                 char_ready,
  output logic [DATA_BITS-1:0] char_data,
  output logic                 char_valid,
  output logic                 frame_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int SC_W = $clog2(OVERSAMPLE);
  localparam int BC_W = $clog2(DATA_BITS + 1);

  localparam logic [SC_W-1:0] SC_HALF = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  logic                 rx_meta_q;
  logic                 rx_s_q;
  state_t               state_q,       state_d;
  logic [SC_W-1:0]      sample_cnt_q,  sample_cnt_d;
  logic [BC_W-1:0]      bit_cnt_q,     bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,       shift_d;
  logic [DATA_BITS-1:0] char_data_q,   char_data_d;
  logic                 char_valid_q,  char_valid_d;
  logic                 frame_error_q, frame_error_d;
  logic                 overrun_q,     overrun_d;
  logic                 busy_q,        busy_d;

  always_comb begin
    state_d       = state_q;
    sample_cnt_d  = sample_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    char_data_d   = char_data_q;
    char_valid_d  = char_valid_q;
    frame_error_d = 1'b0;
    overrun_d     = 1'b0;

    // Consumer handshake runs every cycle; a delivery below may re-assert valid.
    if (char_valid_q && char_ready) begin
      char_valid_d = 1'b0;
    end

    if (sample_tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_d      = START;
            sample_cnt_d = '0;
          end
        end

        START: begin
          if (sample_cnt_q == SC_HALF) begin
            sample_cnt_d = '0;
            if (rx_s_q) begin
              state_d = IDLE;
            end else begin
              state_d   = DATA;
              bit_cnt_d = '0;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + SC_W'(1);
          end
        end

        DATA: begin
          if (sample_cnt_q == SC_LAST) begin
            shift_d      = {rx_s_q, shift_q[DATA_BITS-1:1]};
            sample_cnt_d = '0;
            bit_cnt_d    = bit_cnt_q + BC_W'(1);
            if (bit_cnt_q == BC_LAST) begin
              state_d = STOP;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + SC_W'(1);
          end
        end

        STOP: begin
          if (sample_cnt_q == SC_LAST) begin
            sample_cnt_d = '0;
            if (rx_s_q) begin
              state_d = IDLE;
              if (!char_valid_q || char_ready) begin
                char_data_d  = shift_q;
                char_valid_d = 1'b1;
              end else begin
                overrun_d = 1'b1;
              end
            end else begin
              state_d       = WAIT_HIGH;
              frame_error_d = 1'b1;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + SC_W'(1);
          end
        end

        WAIT_HIGH: begin
          if (rx_s_q) begin
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      state_q       <= IDLE;
      sample_cnt_q  <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      char_data_q   <= '0;
      char_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      rx_meta_q     <= rx_in;
      rx_s_q        <= rx_meta_q;
      state_q       <= state_d;
      sample_cnt_q  <= sample_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      char_data_q   <= char_data_d;
      char_valid_q  <= char_valid_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
      busy_q        <= busy_d;
    end
  end

  assign char_data   = char_data_q;
  assign char_valid  = char_valid_q;
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_char_receive_controller.sv
// Directed bench for char_receive_controller: framed characters on rx_in with
// hand-computed expectations for data, handshake, pulses and busy timing.
module tb_char_receive_controller;

  localparam int OS = 16;
  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_tick = 1'b1;
  logic          rx_in = 1'b1;
  logic          char_ready = 1'b0;
  logic [DB-1:0] char_data;
  logic          char_valid;
  logic          frame_error;
  logic          overrun;
  logic          busy;

  char_receive_controller #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .rx_in       (rx_in),
    .char_ready  (char_ready),
    .char_data   (char_data),
    .char_valid  (char_valid),
    .frame_error (frame_error),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int busy_cnt = 0;
  bit sparse   = 1'b0;
  int phase    = 0;

  // Tick source: every clk, or one in three when sparse is set.
  always @(posedge clk) begin
    #1;
    if (sparse) begin
      phase       = (phase == 2) ? 0 : phase + 1;
      sample_tick = (phase == 0);
    end else begin
      sample_tick = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (frame_error === 1'b1) fe_cnt++;
    if (overrun === 1'b1)     ov_cnt++;
    if (busy === 1'b1)        busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx_in = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int cpb);
    drive_bit(1'b0, cpb);
    for (int i = 0; i < DB; i++) drive_bit(d[i], cpb);
    drive_bit(stop, cpb);
    rx_in = 1'b1;
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic consume();
    char_ready = 1'b1;
    @(posedge clk);
    #1;
    char_ready = 1'b0;
  endtask

  int fe0;
  int ov0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data",  32'(char_data), 32'h0);
    chk("rst_valid", 32'(char_valid), 32'h0);
    chk("rst_fe",    32'(frame_error), 32'h0);
    chk("rst_ov",    32'(overrun), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    idle(5);

    // Basic receive of 0x55 with the consumer stalled.
    send_frame(8'h55, 1'b1, 16);
    @(negedge clk);
    chk("basic_valid", 32'(char_valid), 32'h1);
    chk("basic_data",  32'(char_data), 32'h55);
    chk("basic_busy",  32'(busy), 32'h0);
    char_ready = 1'b1;
    @(posedge clk);
    #1;
    char_ready = 1'b0;
    @(negedge clk);
    chk("basic_drop", 32'(char_valid), 32'h0);

    // Glitch: low for 4 clk is gone before the start-bit centre.
    idle(10);
    fe0      = fe_cnt;
    busy_cnt = 0;
    rx_in    = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_busy_hi", 32'(busy), 32'h1);
    idle(20);
    chk("glitch_busy_len", 32'(busy_cnt), 32'd8);
    chk("glitch_valid",    32'(char_valid), 32'h0);
    chk("glitch_fe",       32'(fe_cnt - fe0), 32'h0);

    // Framing error followed by a held-low line, then a good frame.
    fe0 = fe_cnt;
    send_frame(8'hA3, 1'b0, 16);
    drive_bit(1'b0, 40);
    idle(40);
    chk("ferr_pulses", 32'(fe_cnt - fe0), 32'd1);
    chk("ferr_valid",  32'(char_valid), 32'h0);
    chk("ferr_busy",   32'(busy), 32'h0);
    send_frame(8'h3C, 1'b1, 16);
    @(negedge clk);
    chk("after_ferr_valid", 32'(char_valid), 32'h1);
    chk("after_ferr_data",  32'(char_data), 32'h3C);
    consume();
    idle(10);

    // Overrun: two back-to-back characters, consumer stalled.
    ov0 = ov_cnt;
    send_frame(8'h12, 1'b1, 16);
    send_frame(8'h34, 1'b1, 16);
    @(negedge clk);
    chk("ovr_pulses", 32'(ov_cnt - ov0), 32'd1);
    chk("ovr_data",   32'(char_data), 32'h12);
    chk("ovr_valid",  32'(char_valid), 32'h1);
    consume();
    idle(20);

    // Accept and load on the same edge: stop sample is the 155th edge after start.
    ov0 = ov_cnt;
    send_frame(8'h12, 1'b1, 16);
    fork
      send_frame(8'h34, 1'b1, 16);
      begin
        repeat (154) @(posedge clk);
        #1;
        char_ready = 1'b1;
        @(negedge clk);
        chk("same_edge_pre_valid", 32'(char_valid), 32'h1);
        chk("same_edge_pre_data",  32'(char_data), 32'h12);
        @(posedge clk);
        #1;
        char_ready = 1'b0;
        @(negedge clk);
        chk("same_edge_valid", 32'(char_valid), 32'h1);
        chk("same_edge_data",  32'(char_data), 32'h34);
      end
    join
    chk("same_edge_no_ovr", 32'(ov_cnt - ov0), 32'h0);

    // Reset during data bit 3 of 0xFF with 0x34 still pending.
    idle(10);
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 56);
    @(negedge clk);
    chk("mid_busy",  32'(busy), 32'h1);
    chk("mid_valid", 32'(char_valid), 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_data",  32'(char_data), 32'h0);
    chk("mrst_valid", 32'(char_valid), 32'h0);
    chk("mrst_fe",    32'(frame_error), 32'h0);
    chk("mrst_ov",    32'(overrun), 32'h0);
    chk("mrst_busy",  32'(busy), 32'h0);
    idle(120);
    chk("mrst_idle_busy",  32'(busy), 32'h0);
    chk("mrst_idle_valid", 32'(char_valid), 32'h0);
    fe0 = fe_cnt;
    send_frame(8'h81, 1'b1, 16);
    @(negedge clk);
    chk("post_rst_valid", 32'(char_valid), 32'h1);
    chk("post_rst_data",  32'(char_data), 32'h81);
    consume();

    // Sparse ticks: one tick per 3 clk, 48 clk per bit.
    sparse = 1'b1;
    idle(10);
    send_frame(8'h5A, 1'b1, 48);
    @(negedge clk);
    chk("sparse_valid", 32'(char_valid), 32'h1);
    chk("sparse_data",  32'(char_data), 32'h5A);
    chk("sparse_fe",    32'(fe_cnt - fe0), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
